// File: rtl/reg_file_param.sv
// Register file with x0 handling, pending-write scoreboard and sequential clear engine; REGFILE_BYPASS_EN adds write-through reads.
// Latency: writes/scoreboard update on the next edge, reads are combinational, clear takes 2**AW cycles.
// Backpressure: none; while clr_busy is high, w_en, iss_en and clr_req are ignored.
module reg_file_param #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            w_en,
    input  logic [AW-1:0]   w_addr,
    input  logic [XLEN-1:0] w_data,
    input  logic [AW-1:0]   r_addr1,
    input  logic [AW-1:0]   r_addr2,
    output logic [XLEN-1:0] r_data1,
    output logic [XLEN-1:0] r_data2,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_rd,
    output logic            busy1,
    output logic            busy2,
    input  logic            clr_req,
    output logic            clr_busy
);

    localparam int NREG = 1 << AW;
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [0:0]      state;
    logic [AW-1:0]   cnt;
    logic            w_ok;

    // A write to a hardwired x0 is dropped entirely.
    assign w_ok = w_en && !((ZERO_REG != 0) && (w_addr == '0));

    // Issue is applied after the writeback clear so a same-address set wins.
    always_comb begin
        busy_nxt = busy;
        if (w_en)
            busy_nxt[w_addr] = 1'b0;
        if (iss_en)
            busy_nxt[iss_rd] = 1'b1;
        if (ZERO_REG != 0)
            busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            busy  <= '0;
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (w_ok)
                        regs[w_addr] <= w_data;
                    if (clr_req) begin
                        state <= S_CLEAR;
                        cnt   <= '0;
                        busy  <= '0;
                    end else begin
                        busy <= busy_nxt;
                    end
                end
                default: begin
                    regs[cnt] <= '0;
                    cnt       <= cnt + 1'b1;
                    if (&cnt)
                        state <= S_IDLE;
                end
            endcase
        end
    end

    assign clr_busy = (state == S_CLEAR);

    always_comb begin
        r_data1 = regs[r_addr1];
        r_data2 = regs[r_addr2];
        busy1   = busy[r_addr1];
        busy2   = busy[r_addr2];
        if ((ZERO_REG != 0) && (r_addr1 == '0))
            r_data1 = '0;
        if ((ZERO_REG != 0) && (r_addr2 == '0))
            r_data2 = '0;
`ifdef REGFILE_BYPASS_EN
        // Write-through: the writeback value is visible and no longer pending this cycle.
        if (w_ok && (state == S_IDLE) && (w_addr == r_addr1)) begin
            r_data1 = w_data;
            busy1   = 1'b0;
        end
        if (w_ok && (state == S_IDLE) && (w_addr == r_addr2)) begin
            r_data2 = w_data;
            busy2   = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: vector table for read/write/scoreboard, hand sequences for bypass, clear and reset.
module tb_reg_file_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_en;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [4:0]  r_addr1, r_addr2;
    logic [31:0] r_data1, r_data2;
    logic        iss_en;
    logic [4:0]  iss_rd;
    logic        busy1, busy2;
    logic        clr_req;
    logic        clr_busy;

    int checks   = 0;
    int failures = 0;

    reg_file_param #(.XLEN(32), .AW(5), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .r_addr1(r_addr1), .r_addr2(r_addr2),
        .r_data1(r_data1), .r_data2(r_data2),
        .iss_en(iss_en), .iss_rd(iss_rd),
        .busy1(busy1), .busy2(busy2),
        .clr_req(clr_req), .clr_busy(clr_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w_en;
        logic [4:0]  w_addr;
        logic [31:0] w_data;
        logic        iss_en;
        logic [4:0]  iss_rd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        eb1;
        logic        eb2;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        w_en = 1'b0; w_addr = '0; w_data = '0;
        iss_en = 1'b0; iss_rd = '0; clr_req = 1'b0;
    endtask

    initial begin
        logic [31:0] rnd;
        logic        bp;
        int          n;
`ifdef REGFILE_BYPASS_EN
        bp = 1'b1;
`else
        bp = 1'b0;
`endif
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  5'd1,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0};
        vecs[1]  = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0,  5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd7,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 5'd7,  32'h00000011, 1'b1, 5'd7,  5'd5,  5'd6,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd7,  32'h00000011, 32'h00000011, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 5'd7,  32'h00000022, 1'b0, 5'd0,  5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd7,  32'h00000022, 32'h00000022, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  5'd7,  32'h0,        32'h00000022, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd7,  32'h0,        32'h00000022, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 5'd31, 32'hCAFEF00D, 1'b0, 5'd0,  5'd5,  5'd7,  32'hDEADBEEF, 32'h00000022, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd31, 5'd30, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0};

        // Reset state, then an asynchronous reset over non-zero contents.
        idle_inputs();
        r_addr1 = 5'd5; r_addr2 = 5'd9;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_init_d1", r_data1, 32'h0);
        chk("rst_init_busy1", {31'b0, busy1}, 32'h0);
        chk("rst_init_clr_busy", {31'b0, clr_busy}, 32'h0);
        rst = 1'b1;
        tick();
        rnd = $urandom | 32'h1;
        w_en = 1'b1; w_addr = 5'd5; w_data = rnd; iss_en = 1'b1; iss_rd = 5'd9;
        tick();
        idle_inputs();
        #1;
        chk("pre_rst_d1", r_data1, rnd);
        chk("pre_rst_busy2", {31'b0, busy2}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_d1", r_data1, 32'h0);
        chk("async_rst_busy2", {31'b0, busy2}, 32'h0);
        chk("async_rst_clr_busy", {31'b0, clr_busy}, 32'h0);
        #1 rst = 1'b1;
        tick();

        // Table: write/read, x0 handling, scoreboard set/clear priority.
        for (int i = 0; i < 12; i++) begin
            w_en = vecs[i].w_en; w_addr = vecs[i].w_addr; w_data = vecs[i].w_data;
            iss_en = vecs[i].iss_en; iss_rd = vecs[i].iss_rd;
            r_addr1 = vecs[i].r1; r_addr2 = vecs[i].r2;
            #1;
            chk($sformatf("vec%0d_d1", i), r_data1, vecs[i].e1);
            chk($sformatf("vec%0d_d2", i), r_data2, vecs[i].e2);
            chk($sformatf("vec%0d_b1", i), {31'b0, busy1}, {31'b0, vecs[i].eb1});
            chk($sformatf("vec%0d_b2", i), {31'b0, busy2}, {31'b0, vecs[i].eb2});
            tick();
        end
        idle_inputs();

        // Same-cycle write and read of x3 while a write is pending.
        iss_en = 1'b1; iss_rd = 5'd3;
        tick();
        idle_inputs();
        w_en = 1'b1; w_addr = 5'd3; w_data = 32'hA5A5A5A5; r_addr1 = 5'd3;
        #1;
        chk("bypass_d1", r_data1, bp ? 32'hA5A5A5A5 : 32'h0);
        chk("bypass_busy1", {31'b0, busy1}, bp ? 32'h0 : 32'h1);
        tick();
        idle_inputs();
        #1;
        chk("after_write_d1", r_data1, 32'hA5A5A5A5);
        chk("after_write_busy1", {31'b0, busy1}, 32'h0);

        // Sequential clear: fill, mark busy, run clear while hammering ignored inputs.
        for (int i = 1; i < 32; i++) begin
            w_en = 1'b1; w_addr = 5'(i); w_data = 32'h1000_0000 | 32'(i);
            tick();
        end
        idle_inputs();
        iss_en = 1'b1; iss_rd = 5'd9;
        tick();
        idle_inputs();
        clr_req = 1'b1;
        #1;
        chk("clr_pre_edge", {31'b0, clr_busy}, 32'h0);
        tick();
        w_en = 1'b1; w_addr = 5'd1; w_data = 32'hFFFF_FFFF;
        iss_en = 1'b1; iss_rd = 5'd2;
        r_addr1 = 5'd20; r_addr2 = 5'd2;
        n = 0;
        while (clr_busy && n < 100) begin
            if (n == 5) begin
                chk("mid_clear_uncleared", r_data1, 32'h1000_0014);
                chk("mid_clear_cleared", r_data2, 32'h0);
            end
            n++;
            tick();
        end
        idle_inputs();
        chk("clear_cycles", 32'(n), 32'd32);
        for (int i = 0; i < 32; i++) begin
            r_addr1 = 5'(i); r_addr2 = 5'(31 - i);
            #1;
            chk($sformatf("cleared_x%0d", i), r_data1 | r_data2, 32'h0);
        end
        r_addr1 = 5'd9; r_addr2 = 5'd2;
        #1;
        chk("clear_busy9", {31'b0, busy1}, 32'h0);
        chk("clear_iss_ignored", {31'b0, busy2}, 32'h0);

        // Reset in the middle of a clear.
        w_en = 1'b1; w_addr = 5'd20; w_data = 32'h2020;
        tick();
        idle_inputs();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        r_addr1 = 5'd20;
        #1;
        chk("rst_clear_pre_busy", {31'b0, clr_busy}, 32'h1);
        chk("rst_clear_pre_d1", r_data1, 32'h2020);
        rst = 1'b0;
        #1;
        chk("rst_clear_busy", {31'b0, clr_busy}, 32'h0);
        chk("rst_clear_d1", r_data1, 32'h0);
        tick();
        rst = 1'b1;
        repeat (2) tick();
        chk("rst_clear_idle", {31'b0, clr_busy}, 32'h0);
        w_en = 1'b1; w_addr = 5'd8; w_data = 32'h0808_0808; r_addr1 = 5'd8;
        tick();
        idle_inputs();
        #1;
        chk("post_rst_write", r_data1, 32'h0808_0808);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
